// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock controller: stalls/bubbles the 5-stage pipeline for load-use
// hazards, multi-cycle divides and variable-latency data-memory accesses.
`default_nettype none

module hazard_stall_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_Rs,
  input  logic [4:0] id_Rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic [4:0] ex_wreg,
  input  logic       ex_MemRead,
  input  logic       ex_div_start,
  input  logic       mem_req,
  input  logic       mem_data_ok,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       id_ex_stall,
  output logic       id_ex_flush,
  output logic       ex_mem_stall,
  output logic       ex_mem_flush,
  output logic       mem_wb_flush,
  output logic       div_busy,
  output logic       div_done
);

  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_state_e;

  mem_state_e       mem_state_q, mem_state_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mem_stall;
  logic div_stall;
  logic div_release;
  logic lu_raw;
  logic lu;
  logic core_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_state_q <= M_IDLE;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      mem_state_q <= mem_state_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  // Once waiting, only data_ok matters; the instruction advances on the data_ok cycle.
  always_comb begin
    mem_state_d = mem_state_q;
    mem_stall   = 1'b0;
    case (mem_state_q)
      M_IDLE: begin
        if (mem_req && !mem_data_ok) begin
          mem_stall   = 1'b1;
          mem_state_d = M_WAIT;
        end
      end
      M_WAIT: begin
        if (mem_data_ok) begin
          mem_state_d = M_IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: mem_state_d = M_IDLE;
    endcase
  end

  // The counter keeps draining under a memory stall; release waits for the stall to clear.
  always_comb begin
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    div_stall   = 1'b0;
    div_release = 1'b0;
    if (!busy_q) begin
      if (ex_div_start) begin
        div_stall = 1'b1;
        busy_d    = 1'b1;
        cnt_d     = CNT_INIT;
      end
    end else begin
      div_stall = (cnt_q != '0);
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (!mem_stall) begin
        div_release = 1'b1;
        busy_d      = 1'b0;
      end
    end
  end

  always_comb begin
    lu_raw = ex_MemRead && (ex_wreg != 5'd0) &&
             ((id_use_rs && (id_Rs == ex_wreg)) || (id_use_rt && (id_Rt == ex_wreg)));
    core_stall = mem_stall || div_stall;
    lu         = lu_raw && !core_stall;
  end

  assign pc_stall     = rst_n & (core_stall | lu);
  assign if_id_stall  = rst_n & (core_stall | lu);
  assign id_ex_stall  = rst_n & core_stall;
  assign id_ex_flush  = rst_n & lu;
  assign ex_mem_stall = rst_n & mem_stall;
  assign ex_mem_flush = rst_n & div_stall & ~mem_stall;
  assign mem_wb_flush = rst_n & mem_stall;
  assign div_busy     = rst_n & busy_q;
  assign div_done     = rst_n & div_release;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// Directed scoreboard bench for hazard_stall_ctrl with DIV_CYCLES=32.
`default_nettype none

module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_Rs = '0, id_Rt = '0, ex_wreg = '0;
  logic       id_use_rs = 0, id_use_rt = 0, ex_MemRead = 0, ex_div_start = 0;
  logic       mem_req = 0, mem_data_ok = 0;
  logic       pc_stall, if_id_stall, id_ex_stall, id_ex_flush, ex_mem_stall;
  logic       ex_mem_flush, mem_wb_flush, div_busy, div_done;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];
  logic [8:0] obs;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.DIV_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_Rs(id_Rs), .id_Rt(id_Rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_wreg(ex_wreg), .ex_MemRead(ex_MemRead), .ex_div_start(ex_div_start),
    .mem_req(mem_req), .mem_data_ok(mem_data_ok),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush), .div_busy(div_busy), .div_done(div_done)
  );

  assign obs = {pc_stall, if_id_stall, id_ex_stall, id_ex_flush, ex_mem_stall,
                ex_mem_flush, mem_wb_flush, div_busy, div_done};

  // Expected output vector from the externally visible condition of each cycle:
  // m = memory stall, d = divide stall, l = raw load-use match, b = busy, dn = done.
  function automatic logic [8:0] ev(input logic m, d, l, b, dn);
    logic st;
    st = m | d;
    return {st | l, st | l, st, l & ~st, m, d & ~m, m, b, dn};
  endfunction

  task automatic drv(input logic [4:0] rs, rt, input logic urs, urt,
                     input logic [4:0] wreg, input logic mr, dv, rq, ok);
    id_Rs = rs; id_Rt = rt; id_use_rs = urs; id_use_rt = urt;
    ex_wreg = wreg; ex_MemRead = mr; ex_div_start = dv;
    mem_req = rq; mem_data_ok = ok;
  endtask

  task automatic chk(input string tag);
    logic [8:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard empty observed=%b", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, e);
      end
    end
  endtask

  task automatic cyc(input string tag, input logic [8:0] e);
    exp_q.push_back(e);
    @(negedge clk);
    chk(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state, and reset dominance over active inputs
    #3;
    exp_q.push_back(9'b0);
    chk("reset_idle");
    drv(5'd8, 5'd0, 1, 0, 5'd8, 1, 1, 1, 0);
    #1;
    exp_q.push_back(9'b0);
    chk("reset_forces_zero");
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    cyc("idle", ev(0, 0, 0, 0, 0));

    // load-use
    drv(5'd8, 5'd0, 1, 0, 5'd8, 1, 0, 0, 0);
    cyc("lu_rs", ev(0, 0, 1, 0, 0));
    drv(5'd8, 5'd0, 1, 0, 5'd3, 0, 0, 0, 0);
    cyc("lu_after", ev(0, 0, 0, 0, 0));
    drv(5'd1, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0);
    cyc("lu_rt", ev(0, 0, 1, 0, 0));
    drv(5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0);
    cyc("lu_r0", ev(0, 0, 0, 0, 0));
    drv(5'd8, 5'd8, 0, 0, 5'd8, 1, 0, 0, 0);
    cyc("lu_unused", ev(0, 0, 0, 0, 0));
    drv(5'd8, 5'd9, 1, 1, 5'd8, 0, 0, 0, 0);
    cyc("lu_noload", ev(0, 0, 0, 0, 0));

    // memory wait of 3 cycles, then zero-wait
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("mem_w1", ev(1, 0, 0, 0, 0));
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("mem_w2", ev(1, 0, 0, 0, 0));
    cyc("mem_w3", ev(1, 0, 0, 0, 0));
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("mem_ok", ev(0, 0, 0, 0, 0));
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc("mem_zero_wait", ev(0, 0, 0, 0, 0));
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("mem_idle", ev(0, 0, 0, 0, 0));

    // plain divide: 32 stall cycles, done in cycle 33
    drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("div_c1", ev(0, 1, 0, 0, 0));
    for (int i = 2; i <= 32; i++) cyc($sformatf("div_c%0d", i), ev(0, 1, 0, 1, 0));
    cyc("div_c33", ev(0, 0, 0, 1, 1));
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("div_c34", ev(0, 0, 0, 0, 0));

    // load-use suppressed while divide stalls
    drv(5'd8, 5'd0, 1, 0, 5'd8, 1, 1, 0, 0);
    cyc("sup_c1", ev(0, 1, 1, 0, 0));
    for (int i = 2; i <= 32; i++) cyc($sformatf("sup_c%0d", i), ev(0, 1, 1, 1, 0));
    cyc("sup_c33", ev(0, 0, 1, 1, 1));
    drv(5'd8, 5'd0, 1, 0, 5'd8, 1, 0, 0, 0);
    cyc("sup_after", ev(0, 0, 1, 0, 0));
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("sup_clear", ev(0, 0, 0, 0, 0));

    // overlap: mem wait from divide cycle 30 through 40
    drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("ovl_c1", ev(0, 1, 0, 0, 0));
    for (int i = 2; i <= 29; i++) cyc($sformatf("ovl_c%0d", i), ev(0, 1, 0, 1, 0));
    drv(0, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc("ovl_c30", ev(1, 1, 0, 1, 0));
    drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("ovl_c31", ev(1, 1, 0, 1, 0));
    cyc("ovl_c32", ev(1, 1, 0, 1, 0));
    for (int i = 33; i <= 40; i++) cyc($sformatf("ovl_c%0d", i), ev(1, 0, 0, 1, 0));
    drv(0, 0, 0, 0, 0, 0, 1, 0, 1);
    cyc("ovl_c41", ev(0, 0, 0, 1, 1));
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("ovl_c42", ev(0, 0, 0, 0, 0));

    // reset mid-divide (cnt=10) and mid-wait
    drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc("rst_c1", ev(0, 1, 0, 0, 0));
    for (int i = 2; i <= 21; i++) cyc($sformatf("rst_c%0d", i), ev(0, 1, 0, 1, 0));
    drv(0, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc("rst_c22", ev(1, 1, 0, 1, 0));
    drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
    exp_q.push_back(ev(1, 1, 0, 1, 0));
    @(negedge clk);
    chk("rst_c23");
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(9'b0);
    chk("rst_async");
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("rst_release", ev(0, 0, 0, 0, 0));
    cyc("rst_release2", ev(0, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline interlock controller for the 5-stage MIPS core: the complement of the MEM/WB→EX forwarding path. It stalls or bubbles the stages when forwarding cannot supply a value in time. Three cases are handled:

- load-use RAW between ID and a load in EX;
- a multi-cycle divide occupying EX;
- a variable-latency data-memory access waiting in MEM.

Its outputs drive the PC and every pipeline register's hold/flush controls.

## Interface
Parameters:
- DIV_CYCLES, default 32: number of stall cycles a divide costs. Legal range 2..64.

Ports (name, direction, width, meaning):
- clk, in, 1: core clock; all state updates on rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- id_Rs, in, 5: source register rs of the instruction in ID.
- id_Rt, in, 5: source register rt of the instruction in ID.
- id_use_rs, in, 1: ID instruction actually reads rs.
- id_use_rt, in, 1: ID instruction actually reads rt.
- ex_wreg, in, 5: destination register of the instruction in EX.
- ex_MemRead, in, 1: EX instruction is a load.
- ex_div_start, in, 1: EX instruction is div/divu; level, held while the instruction sits in EX.
- mem_req, in, 1: MEM instruction issues a data-memory access this cycle.
- mem_data_ok, in, 1: data memory completes the access this cycle.
- pc_stall, out, 1: hold PC.
- if_id_stall, out, 1: hold IF/ID.
- id_ex_stall, out, 1: hold ID/EX.
- id_ex_flush, out, 1: load a bubble into ID/EX.
- ex_mem_stall, out, 1: hold EX/MEM.
- ex_mem_flush, out, 1: load a bubble into EX/MEM.
- mem_wb_flush, out, 1: load a bubble into MEM/WB.
- div_busy, out, 1: divider occupied.
- div_done, out, 1: one-cycle pulse when the divide result is released.

## Operation
State:
- Memory FSM, two states: M_IDLE and M_WAIT.
- Divider: busy flag plus down-counter cnt, width ceil(log2(DIV_CYCLES)).

Memory FSM:
- In M_IDLE:
  - mem_req=1 and mem_data_ok=0: mem_stall=1, next state M_WAIT.
  - mem_req=1 and mem_data_ok=1: no stall.
- In M_WAIT:
  - mem_req is ignored.
  - mem_stall=1 while mem_data_ok=0.
  - On mem_data_ok=1: mem_stall=0 and next state M_IDLE, so the instruction advances that same cycle.

Divider:
- Start: busy=0 and ex_div_start=1 → div_stall=1, busy←1, cnt←DIV_CYCLES-1.
- While busy=1:
  - ex_div_start is ignored.
  - cnt decrements every cycle, saturating at 0, independent of other stalls.
  - div_stall = (cnt≠0).
- Release: busy=1, cnt=0 and mem_stall=0 → div_done=1, busy←0.
  - If mem_stall=1 at that point, busy holds with cnt=0 until mem_stall drops.
  - div_stall is 0 during this hold; the mem stall alone holds EX.

Load-use hazard:
- lu = ex_MemRead & (ex_wreg≠0) & ((id_use_rs & id_Rs==ex_wreg) | (id_use_rt & id_Rt==ex_wreg)).
- lu is suppressed whenever mem_stall or div_stall is 1; the hazard is re-evaluated once they clear.

Output equations (combinational):
- pc_stall = if_id_stall = mem_stall | div_stall | lu.
- id_ex_stall = mem_stall | div_stall.
- id_ex_flush = lu & ~id_ex_stall.
- ex_mem_stall = mem_stall.
- ex_mem_flush = div_stall & ~mem_stall.
- mem_wb_flush = mem_stall.
- div_busy = busy.
- A stall and a flush on the same register are never both 1.

Reset:
- Memory FSM ← M_IDLE, busy ← 0, cnt ← 0.
- While rst_n=0, every output is forced to 0 regardless of inputs.
- Reset asserted mid-divide or mid-wait aborts the operation; the first cycle after release behaves as idle.

## Timing
- Load-use costs exactly 1 bubble. The stall and flush are asserted in the cycle the load is in EX; the next cycle the load is in MEM, lu=0, and the dependent instruction proceeds and picks up forwarded data.
- Divide costs exactly DIV_CYCLES stall cycles when no memory stall overlaps:
  - the div occupies EX for DIV_CYCLES+1 cycles;
  - div_done is asserted in its last EX cycle.
- Memory stall length equals the number of cycles from mem_req to mem_data_ok. Zero-wait memory (data_ok in the same cycle as req) costs 0 cycles.
- No registered output: all outputs settle in the same cycle as their inputs.
- Reaching cnt=0 at the same time as mem_data_ok: div_done pulses in that cycle.

## Test plan
- Load-use: ex_MemRead=1, ex_wreg=8, id_Rs=8, id_use_rs=1 → one cycle with pc_stall=if_id_stall=id_ex_flush=1 and id_ex_stall=0. With ex_wreg=0, all outputs stay 0.
- Divide with DIV_CYCLES=32: ex_div_start held high → id_ex_stall=ex_mem_flush=1 for 32 consecutive cycles; div_done=1 in cycle 33; div_busy=0 in cycle 34.
- Memory: mem_req=1 with mem_data_ok arriving 3 cycles later → mem_wb_flush=ex_mem_stall=1 for 3 cycles, 0 on the data_ok cycle. mem_req=1 with mem_data_ok=1 in the same cycle → no stall.
- Overlap: start a divide, then hold mem_data_ok low from divide cycle 30 through cycle 40 → cnt reaches 0 under the mem stall; div_done pulses exactly on the mem_data_ok cycle; ex_mem_flush is never 1 in the same cycle as ex_mem_stall.
- Suppression: load-use condition present while a divide is busy → id_ex_flush stays 0 until div_done; afterwards the hazard is evaluated normally.
- Reset: pull rst_n low during M_WAIT with cnt=10 → all outputs go to 0 asynchronously. After release with mem_req=0 and ex_div_start=0 → no stall and div_busy=0.
